// File: rtl/split_burst_din.sv
// Burst word splitter: replays one wide memory word as burst_index digit-vectors, MSB slice first.
// Optional din_last output enabled by defining SPLIT_LAST_EN.
module split_burst_din #(
    parameter int no_of_digits = 8,
    parameter int radix_bits   = 3,
    parameter int burst_index  = 8,
    localparam int W  = (no_of_digits + 1) * radix_bits,
    localparam int B  = W * burst_index,
    localparam int CW = (burst_index > 1) ? $clog2(burst_index) : 1
) (
    input  logic         variable_clk,
    input  logic         rst_n,
    input  logic [B-1:0] mem_out,
    input  logic         mem_valid,
    output logic         mem_ready,
    output logic [W-1:0] din,
    output logic         din_valid,
`ifdef SPLIT_LAST_EN
    input  logic         din_ready,
    output logic         din_last
`else
    input  logic         din_ready
`endif
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(burst_index - 1);

    state_t        state_q, state_d;
    logic [B-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_last;

    assign is_last   = (cnt_q == LAST_CNT);
    assign din       = data_q[B-1 -: W];
    assign din_valid = (state_q == STREAM);
    assign mem_ready = (state_q == IDLE)
                     | ((state_q == STREAM) & din_ready & is_last);

`ifdef SPLIT_LAST_EN
    assign din_last = (state_q == STREAM) & is_last;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    data_d  = mem_out;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (din_ready) begin
                    if (!is_last) begin
                        data_d = data_q << W;
                        cnt_d  = cnt_q + CW'(1);
                    end else if (mem_valid) begin
                        // back-to-back reload, no bubble between bursts
                        data_d = mem_out;
                        cnt_d  = '0;
                    end else begin
                        data_d  = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge variable_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_split_burst_din.sv
// Directed bench for split_burst_din: default burst of 8 and a burst_index=1 instance.
module tb_split_burst_din;

    localparam int W  = 27;
    localparam int B  = W * 8;

    logic         clk;
    logic         rst_n;
    logic [B-1:0] mem_out_a;
    logic         mem_valid_a, mem_ready_a, din_valid_a, din_ready_a;
    logic [W-1:0] din_a;
    logic [W-1:0] mem_out_b;
    logic         mem_valid_b, mem_ready_b, din_valid_b, din_ready_b;
    logic [W-1:0] din_b;
`ifdef SPLIT_LAST_EN
    logic         din_last_a, din_last_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    split_burst_din #(.no_of_digits(8), .radix_bits(3), .burst_index(8)) dut_a (
        .variable_clk(clk),
        .rst_n(rst_n),
        .mem_out(mem_out_a),
        .mem_valid(mem_valid_a),
        .mem_ready(mem_ready_a),
        .din(din_a),
        .din_valid(din_valid_a),
`ifdef SPLIT_LAST_EN
        .din_ready(din_ready_a),
        .din_last(din_last_a)
`else
        .din_ready(din_ready_a)
`endif
    );

    split_burst_din #(.no_of_digits(8), .radix_bits(3), .burst_index(1)) dut_b (
        .variable_clk(clk),
        .rst_n(rst_n),
        .mem_out(mem_out_b),
        .mem_valid(mem_valid_b),
        .mem_ready(mem_ready_b),
        .din(din_b),
        .din_valid(din_valid_b),
`ifdef SPLIT_LAST_EN
        .din_ready(din_ready_b),
        .din_last(din_last_b)
`else
        .din_ready(din_ready_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // word i of the burst (i=0 in the MSB slice) carries base+i
    function automatic logic [B-1:0] pack(input int base);
        logic [B-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            v[B-1-i*W -: W] = W'(base + i);
        return v;
    endfunction

    task automatic check_word_a(input string tag, input int k, input int last_k);
        chk({tag, "_din"}, 64'(din_a), 64'(k));
        chk({tag, "_valid"}, 64'(din_valid_a), 64'd1);
`ifdef SPLIT_LAST_EN
        chk({tag, "_last"}, 64'(din_last_a), 64'(k == last_k || k == 16));
`endif
    endtask

    task automatic check_idle_a(input string tag);
        chk({tag, "_idle_valid"}, 64'(din_valid_a), 64'd0);
        chk({tag, "_idle_din"}, 64'(din_a), 64'd0);
        chk({tag, "_idle_mrdy"}, 64'(mem_ready_a), 64'd1);
`ifdef SPLIT_LAST_EN
        chk({tag, "_idle_last"}, 64'(din_last_a), 64'd0);
`endif
    endtask

    initial begin
        rst_n       = 1'b0;
        mem_out_a   = '0;
        mem_valid_a = 1'b0;
        din_ready_a = 1'b0;
        mem_out_b   = '0;
        mem_valid_b = 1'b0;
        din_ready_b = 1'b0;
        #2;
        check_idle_a("reset");
        chk("reset_b_valid", 64'(din_valid_b), 64'd0);
        chk("reset_b_mrdy", 64'(mem_ready_b), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // single burst 1..8
        mem_out_a   = pack(1);
        mem_valid_a = 1'b1;
        din_ready_a = 1'b1;
        chk("single_accept_mrdy", 64'(mem_ready_a), 64'd1);
        tick();
        mem_valid_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check_word_a("single", k, 8);
            chk("single_mrdy", 64'(mem_ready_a), 64'(k == 8));
            tick();
        end
        check_idle_a("single_end");

        // back-to-back 1..16, second burst held valid from the start
        mem_out_a   = pack(1);
        mem_valid_a = 1'b1;
        tick();
        mem_out_a = pack(9);
        for (int k = 1; k <= 16; k++) begin
            check_word_a("b2b", k, 8);
            chk("b2b_mrdy", 64'(mem_ready_a), 64'(k == 8 || k == 16));
            tick();
            if (k == 8) mem_valid_a = 1'b0;
        end
        check_idle_a("b2b_end");

        // backpressure while din=3
        mem_out_a   = pack(1);
        mem_valid_a = 1'b1;
        tick();
        mem_valid_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) begin
                din_ready_a = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    tick();
                    check_word_a("stall", 3, 8);
                    chk("stall_mrdy", 64'(mem_ready_a), 64'd0);
                end
                din_ready_a = 1'b1;
            end
            check_word_a("bp", k, 8);
            tick();
        end
        check_idle_a("bp_end");

        // reset after 3 words sent, then reload starts at word 0
        mem_out_a   = pack(1);
        mem_valid_a = 1'b1;
        tick();
        mem_valid_a = 1'b0;
        tick();
        tick();
        tick();
        check_word_a("pre_rst", 4, 8);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_a("mid_rst");
        tick();
        rst_n       = 1'b1;
        mem_out_a   = pack(9);
        mem_valid_a = 1'b1;
        tick();
        mem_valid_a = 1'b0;
        check_word_a("after_rst", 9, 0);
        chk("after_rst_mrdy", 64'(mem_ready_a), 64'd0);
        for (int s = 0; s < 8; s++) tick();
        check_idle_a("after_rst_end");

        // burst_index=1, continuous stream 5,6,7
        din_ready_b = 1'b1;
        mem_valid_b = 1'b1;
        mem_out_b   = W'(5);
        chk("b1_accept_mrdy", 64'(mem_ready_b), 64'd1);
        for (int k = 5; k <= 7; k++) begin
            tick();
            if (k < 7) mem_out_b = W'(k + 1);
            else mem_valid_b = 1'b0;
            chk("b1_din", 64'(din_b), 64'(k));
            chk("b1_valid", 64'(din_valid_b), 64'd1);
            chk("b1_mrdy", 64'(mem_ready_b), 64'd1);
`ifdef SPLIT_LAST_EN
            chk("b1_last", 64'(din_last_b), 64'd1);
`endif
        end
        tick();
        chk("b1_end_valid", 64'(din_valid_b), 64'd0);
        chk("b1_end_din", 64'(din_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
